// File: rtl/ulpi_sched_pkg.sv
// ULPI register-write scheduler: state encoding and the PHY boot table written after reset.
// The boot phase is only compiled into ulpi_reg_sched when ULPI_SCHED_INIT_EN is defined.
package ulpi_sched_pkg;

   typedef enum logic [2:0] {
      BOOT_WAIT = 3'd0,
      SEL       = 3'd1,
      ISSUE     = 3'd2,
      ARM       = 3'd3,
      WAIT      = 3'd4,
      IDLE      = 3'd5
   } sched_state_t;

   localparam int INIT_LEN = 3;
   localparam int IDX_W    = 2;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] val;
   } reg_wr_t;

   function automatic reg_wr_t init_entry(input logic [IDX_W-1:0] idx);
      reg_wr_t e;
      case (idx)
         2'd0:    e = '{addr: 6'h04, val: 8'h49};  // Function Control: non-driving, FS, SuspendM
         2'd1:    e = '{addr: 6'h0A, val: 8'h00};  // OTG Control
         default: e = '{addr: 6'h0D, val: 8'h00};  // USB Interrupt Enable Rising
      endcase
      return e;
   endfunction

endpackage

// File: rtl/ulpi_rr_arb.sv
// Two-way round-robin arbiter; last_b_reg remembers who was served last so a tie
// goes to the other requester. Reset leaves b as last served, so a wins the first tie.
module ulpi_rr_arb (
   input  logic clk_ULPI,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic take,
   output logic grant_b
);

   logic last_b_reg;

   assign grant_b = req_b && (!req_a || !last_b_reg);

   always_ff @(posedge clk_ULPI) begin
      if (!rst) begin
         last_b_reg <= 1'b1;
      end else if (take) begin
         last_b_reg <= grant_b;
      end
   end

endmodule

// File: rtl/ulpi_reg_sched.sv
// Schedules ULPI PHY register writes: optional boot table (ULPI_SCHED_INIT_EN), then
// round-robin service of two requesters through a shared register-write engine.
module ulpi_reg_sched
   import ulpi_sched_pkg::*;
#(
   parameter int BOOT_DLY = 1024
) (
   input  logic       clk_ULPI,
   input  logic       rst,
   input  logic       DIR,
   input  logic       req_a,
   input  logic       req_b,
   input  logic [5:0] addr_a,
   input  logic [5:0] addr_b,
   input  logic [7:0] val_a,
   input  logic [7:0] val_b,
   output logic       ack_a,
   output logic       ack_b,
   output logic       wr_PrW,
   output logic [5:0] wr_ADDR,
   output logic [7:0] wr_VAL,
   input  logic       wr_busy,
   output logic       init_done,
   output logic       sched_busy
);

   localparam int               CNT_W    = (BOOT_DLY > 1) ? $clog2(BOOT_DLY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_DLY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);

`ifdef ULPI_SCHED_INIT_EN
   localparam sched_state_t RST_STATE = BOOT_WAIT;
`else
   localparam sched_state_t RST_STATE = IDLE;
`endif

   sched_state_t     state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   reg_wr_t          wr_reg, wr_next;
   logic             gnt_b_reg, gnt_b_next;
   logic             init_done_reg, init_done_next;
   logic             arb_take, arb_grant_b;
   logic             write_done;

   ulpi_rr_arb u_arb (
      .clk_ULPI (clk_ULPI),
      .rst      (rst),
      .req_a    (req_a),
      .req_b    (req_b),
      .take     (arb_take),
      .grant_b  (arb_grant_b)
   );

   always_ff @(posedge clk_ULPI) begin
      if (!rst) begin
         state_reg     <= RST_STATE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         wr_reg        <= '0;
         gnt_b_reg     <= 1'b0;
         init_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         wr_reg        <= wr_next;
         gnt_b_reg     <= gnt_b_next;
         init_done_reg <= init_done_next;
      end
   end

   assign write_done = (state_reg == WAIT) && !wr_busy;

   // Strobes are qualified by rst so nothing fires in a cycle that is being reset.
   assign wr_PrW     = rst && (state_reg == ISSUE) && !DIR && !wr_busy;
   assign ack_a      = rst && write_done && init_done_reg && !gnt_b_reg;
   assign ack_b      = rst && write_done && init_done_reg && gnt_b_reg;
   assign sched_busy = rst && (state_reg != IDLE);
   assign wr_ADDR    = wr_reg.addr;
   assign wr_VAL     = wr_reg.val;
   assign init_done  = init_done_reg;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      idx_next       = idx_reg;
      wr_next        = wr_reg;
      gnt_b_next     = gnt_b_reg;
      arb_take       = 1'b0;
`ifdef ULPI_SCHED_INIT_EN
      init_done_next = init_done_reg;
`else
      init_done_next = 1'b1;
`endif
      case (state_reg)
         BOOT_WAIT: begin
            if (cnt_reg == CNT_LAST) begin
               idx_next   = '0;
               state_next = SEL;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         SEL: begin
            wr_next    = init_entry(idx_reg);
            state_next = ISSUE;
         end
         IDLE: begin
            // Requests raised during the boot phase simply wait here until init_done.
            if (init_done_reg && (req_a || req_b)) begin
               arb_take   = 1'b1;
               gnt_b_next = arb_grant_b;
               wr_next    = arb_grant_b ? {addr_b, val_b} : {addr_a, val_a};
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (!DIR && !wr_busy) state_next = ARM;
         end
         ARM: begin
            if (wr_busy) state_next = WAIT;
         end
         WAIT: begin
            if (!wr_busy) begin
               if (!init_done_reg) begin
                  if (idx_reg == IDX_LAST) begin
                     init_done_next = 1'b1;
                     state_next     = IDLE;
                  end else begin
                     idx_next   = idx_reg + IDX_W'(1);
                     state_next = SEL;
                  end
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = RST_STATE;
      endcase
   end

endmodule

// File: tb/tb_ulpi_reg_sched.sv
// Self-checking bench for ulpi_reg_sched: directed vector table plus hand-written
// sequences for boot, tie-break, DIR stall and mid-write reset. Works with or without ULPI_SCHED_INIT_EN.
`timescale 1ns/1ps
module tb_ulpi_reg_sched;

   localparam int BOOT_DLY = 4;
`ifdef ULPI_SCHED_INIT_EN
   localparam int EXP_BOOT = 3;
   localparam int EXP_SB   = 1;
`else
   localparam int EXP_BOOT = 0;
   localparam int EXP_SB   = 0;
`endif

   logic       clk_ULPI = 1'b0;
   logic       rst      = 1'b0;
   logic       DIR      = 1'b0;
   logic       req_a    = 1'b0;
   logic       req_b    = 1'b0;
   logic [5:0] addr_a   = '0;
   logic [5:0] addr_b   = '0;
   logic [7:0] val_a    = '0;
   logic [7:0] val_b    = '0;
   logic       wr_busy  = 1'b0;
   logic       ack_a, ack_b, wr_PrW, init_done, sched_busy;
   logic [5:0] wr_ADDR;
   logic [7:0] wr_VAL;

   int checks = 0;
   int fails  = 0;
   int both_ack = 0;
   logic [13:0] wlog [$];
   logic [13:0] boot_tab [3] = '{{6'h04, 8'h49}, {6'h0A, 8'h00}, {6'h0D, 8'h00}};

   always #8 clk_ULPI = ~clk_ULPI;

   ulpi_reg_sched #(.BOOT_DLY(BOOT_DLY)) dut (
      .clk_ULPI   (clk_ULPI),
      .rst        (rst),
      .DIR        (DIR),
      .req_a      (req_a),
      .req_b      (req_b),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .val_a      (val_a),
      .val_b      (val_b),
      .ack_a      (ack_a),
      .ack_b      (ack_b),
      .wr_PrW     (wr_PrW),
      .wr_ADDR    (wr_ADDR),
      .wr_VAL     (wr_VAL),
      .wr_busy    (wr_busy),
      .init_done  (init_done),
      .sched_busy (sched_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ack(output logic a, output logic b, output logic ok);
      a = 1'b0; b = 1'b0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_ULPI);
         if (ack_a || ack_b) begin
            a = ack_a; b = ack_b; ok = 1'b1;
            break;
         end
      end
   endtask

   // Engine model: logs each start pulse and stays busy for 3 cycles after it.
   initial begin
      forever begin
         @(negedge clk_ULPI);
         if (ack_a && ack_b) both_ack++;
         if (wr_PrW === 1'b1) begin
            wlog.push_back({wr_ADDR, wr_VAL});
            @(posedge clk_ULPI); #1 wr_busy = 1'b1;
            repeat (3) @(posedge clk_ULPI);
            #1 wr_busy = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       ra, rb;
      logic [5:0] aa, ab;
      logic [7:0] va, vb;
      logic [5:0] ea;
      logic [7:0] ev;
      logic       eb;
   } vec_t;

   initial begin
      vec_t vec [8];
      logic a, b, ok;
      int   n, early, low_cnt, spurious;

      vec[0] = '{ra:1, rb:0, aa:6'h04, va:8'h48, ab:6'h00, vb:8'h00, ea:6'h04, ev:8'h48, eb:0};
      vec[1] = '{ra:1, rb:1, aa:6'h10, va:8'h11, ab:6'h20, vb:8'h22, ea:6'h20, ev:8'h22, eb:1};
      vec[2] = '{ra:1, rb:1, aa:6'h11, va:8'h33, ab:6'h21, vb:8'h44, ea:6'h11, ev:8'h33, eb:0};
      vec[3] = '{ra:0, rb:1, aa:6'h00, va:8'h00, ab:6'h22, vb:8'h55, ea:6'h22, ev:8'h55, eb:1};
      vec[4] = '{ra:0, rb:1, aa:6'h00, va:8'h00, ab:6'h23, vb:8'h66, ea:6'h23, ev:8'h66, eb:1};
      vec[5] = '{ra:1, rb:1, aa:6'h12, va:8'h77, ab:6'h24, vb:8'h88, ea:6'h12, ev:8'h77, eb:0};
      vec[6] = '{ra:1, rb:0, aa:6'h13, va:8'h99, ab:6'h00, vb:8'h00, ea:6'h13, ev:8'h99, eb:0};
      vec[7] = '{ra:1, rb:1, aa:6'h14, va:8'hAA, ab:6'h25, vb:8'hBB, ea:6'h25, ev:8'hBB, eb:1};

      // Reset values
      repeat (2) @(posedge clk_ULPI);
      @(negedge clk_ULPI);
      chk("rst_wr_PrW", wr_PrW, 0);
      chk("rst_ack_a", ack_a, 0);
      chk("rst_ack_b", ack_b, 0);
      chk("rst_wr_ADDR", wr_ADDR, 0);
      chk("rst_wr_VAL", wr_VAL, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_sched_busy", sched_busy, 0);

      // Release reset with req_b already pending (must wait for the boot phase)
      @(posedge clk_ULPI); #1;
      rst = 1'b1; req_b = 1'b1; addr_b = 6'h17; val_b = 8'hA5;
      @(negedge clk_ULPI);
      chk("rel_init_done", init_done, 0);
      chk("rel_sched_busy", sched_busy, EXP_SB);
`ifdef ULPI_SCHED_INIT_EN
      early = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_ULPI);
         if (wr_PrW !== 1'b0) early++;
      end
      chk("boot_early_prw", early, 0);
      @(negedge clk_ULPI);
      chk("boot_first_prw", wr_PrW, 1);
      chk("boot_first_addr", wr_ADDR, 6'h04);
      chk("boot_first_val", wr_VAL, 8'h49);
`else
      @(negedge clk_ULPI);
      chk("noinit_done_1cyc", init_done, 1);
`endif
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (init_done === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk_ULPI);
      end
      chk("init_done_seen", ok, 1);
      chk("boot_write_count", wlog.size(), EXP_BOOT);
`ifdef ULPI_SCHED_INIT_EN
      if (wlog.size() >= 3)
         for (int i = 0; i < 3; i++) chk($sformatf("boot_entry%0d", i), wlog[i], boot_tab[i]);
`endif
      wait_ack(a, b, ok);
      chk("pend_b_ack_seen", ok, 1);
      chk("pend_b_ack_b", b, 1);
      chk("pend_b_ack_a", a, 0);
      chk("pend_b_count", wlog.size(), EXP_BOOT + 1);
      chk("pend_b_entry", wlog[wlog.size()-1], {6'h17, 8'hA5});
      @(posedge clk_ULPI); #1 req_b = 1'b0;

      // Vector table: one transaction per record, started from IDLE with an idle engine
      for (int v = 0; v < 8; v++) begin
         req_a = vec[v].ra; req_b = vec[v].rb;
         addr_a = vec[v].aa; val_a = vec[v].va;
         addr_b = vec[v].ab; val_b = vec[v].vb;
         n = wlog.size();
         @(negedge clk_ULPI);
         chk($sformatf("v%0d_prw_idle", v), wr_PrW, 0);
         @(negedge clk_ULPI);
         chk($sformatf("v%0d_prw_lat2", v), wr_PrW, 1);
         chk($sformatf("v%0d_addr", v), wr_ADDR, vec[v].ea);
         chk($sformatf("v%0d_val", v), wr_VAL, vec[v].ev);
         wait_ack(a, b, ok);
         chk($sformatf("v%0d_ack_seen", v), ok, 1);
         chk($sformatf("v%0d_ack_b", v), b, vec[v].eb);
         chk($sformatf("v%0d_ack_a", v), a, !vec[v].eb);
         chk($sformatf("v%0d_one_prw", v), wlog.size(), n + 1);
         $display("txn %0d: addr=%h val=%h ack_a=%b ack_b=%b", v, wr_ADDR, wr_VAL, a, b);
         @(posedge clk_ULPI); #1 req_a = 1'b0; req_b = 1'b0;
      end

      // Simultaneous requests: a first, b held and served next, following tie back to a
      req_a = 1'b1; addr_a = 6'h16; val_a = 8'h5A;
      req_b = 1'b1; addr_b = 6'h17; val_b = 8'hA5;
      wait_ack(a, b, ok);
      chk("tie_first_ack_a", a, 1);
      chk("tie_first_entry", wlog[wlog.size()-1], {6'h16, 8'h5A});
      @(posedge clk_ULPI); #1 req_a = 1'b0;
      wait_ack(a, b, ok);
      chk("tie_second_ack_b", b, 1);
      chk("tie_second_entry", wlog[wlog.size()-1], {6'h17, 8'hA5});
      @(posedge clk_ULPI); #1 req_b = 1'b0;
      req_a = 1'b1; req_b = 1'b1;
      @(negedge clk_ULPI);
      @(negedge clk_ULPI);
      chk("tie_again_addr", wr_ADDR, 6'h16);
      wait_ack(a, b, ok);
      chk("tie_again_ack_a", a, 1);
      @(posedge clk_ULPI); #1 req_a = 1'b0; req_b = 1'b0;

      // PHY owns the bus: start pulse held off until DIR drops
      DIR = 1'b1; req_a = 1'b1; addr_a = 6'h05; val_a = 8'h01;
      @(negedge clk_ULPI);
      low_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_ULPI);
         if (wr_PrW === 1'b0 && sched_busy === 1'b1) low_cnt++;
      end
      chk("dir_hold_cycles", low_cnt, 10);
      @(posedge clk_ULPI); #1 DIR = 1'b0;
      @(negedge clk_ULPI);
      chk("dir_release_prw", wr_PrW, 1);
      chk("dir_release_addr", wr_ADDR, 6'h05);
      wait_ack(a, b, ok);
      chk("dir_ack_a", a, 1);
      @(posedge clk_ULPI); #1 req_a = 1'b0;

      // One-cycle reset while the write sits in WAIT: abandoned, never acked
      n = wlog.size();
      req_a = 1'b1; addr_a = 6'h30; val_a = 8'h3C;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_ULPI);
         if (wr_busy === 1'b1) begin ok = 1'b1; break; end
      end
      chk("mid_busy_seen", ok, 1);
      @(posedge clk_ULPI); #1 rst = 1'b0; req_a = 1'b0;
      @(negedge clk_ULPI);
      chk("mid_rst_ack_a", ack_a, 0);
      chk("mid_rst_prw", wr_PrW, 0);
      chk("mid_rst_sched_busy", sched_busy, 0);
      @(posedge clk_ULPI); #1 rst = 1'b1;
      @(negedge clk_ULPI);
      chk("mid_rst_addr", wr_ADDR, 0);
      chk("mid_rst_val", wr_VAL, 0);
      chk("mid_rst_init_done", init_done, 0);
      spurious = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (init_done === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk_ULPI);
         if (ack_a || ack_b) spurious++;
      end
      chk("mid_init_done_seen", ok, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_ULPI);
         if (ack_a || ack_b) spurious++;
      end
      chk("mid_no_ack", spurious, 0);
      chk("mid_write_count", wlog.size(), n + 1 + EXP_BOOT);
`ifdef ULPI_SCHED_INIT_EN
      if (wlog.size() == n + 4)
         for (int i = 0; i < 3; i++) chk($sformatf("reboot_entry%0d", i), wlog[n+1+i], boot_tab[i]);
`endif

      chk("dual_ack_cycles", both_ack, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
